// File: rtl/rng_word_packer.sv
// rng_word_packer
//   Packs the raw serial bit stream from the LFSR stage into OUT_WIDTH-bit
//   words and offers them to a consumer over a valid/ready handshake. A
//   repetition-count health test raises a sticky fault when the source
//   looks stuck; once faulted, no new bits are packed, but any word already
//   assembled can still be handed off.
//
//   Optional feature: define VBB_RNG_VN_DEBIAS_EN to insert a von Neumann
//   debiaser between the raw stream and the packer. The default build packs
//   every raw bit.
//
// Parameters
//   OUT_WIDTH  output word width (>= 2)
//   RUN_LIMIT  identical consecutive raw bits that trip the fault (>= 2)
//
// Ports
//   clk         clock, all state changes on posedge
//   rst         asynchronous reset, active-high
//   bit_in      raw random bit
//   bit_valid   bit_in is sampled on a posedge where this is 1
//   word_out    packed word, MSB-first, stable while word_valid=1
//   word_valid  word_out holds an unconsumed word
//   word_ready  consumer accepts; transfer on word_valid && word_ready
//   fault       sticky health-test failure
//   overrun     one-cycle pulse: a packable bit was dropped
module rng_word_packer #(
  parameter int OUT_WIDTH = 8,
  parameter int RUN_LIMIT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [OUT_WIDTH-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 fault,
  output logic                 overrun
);

  localparam int CW = $clog2(OUT_WIDTH);
  localparam int RW = $clog2(RUN_LIMIT + 1);

  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 acc_full_q, acc_full_d;
  logic [OUT_WIDTH-1:0] word_out_q, word_out_d;
  logic                 word_valid_q, word_valid_d;
  logic                 fault_q, fault_d;
  logic                 overrun_q, overrun_d;
  logic [RW-1:0]        run_len_q, run_len_d;
  logic                 prev_bit_q, prev_bit_d;

  logic pack_valid;
  logic pack_bit;
  logic out_free;

  // Repetition-count health test on raw bits. run_len of zero means no raw
  // bit has been seen since reset, so the first bit always starts a run of 1.
  always_comb begin
    run_len_d  = run_len_q;
    prev_bit_d = prev_bit_q;
    fault_d    = fault_q;
    if (bit_valid) begin
      prev_bit_d = bit_in;
      if (run_len_q == '0 || bit_in != prev_bit_q) begin
        run_len_d = RW'(1);
      end else if (run_len_q != RW'(RUN_LIMIT)) begin
        run_len_d = run_len_q + 1'b1;
      end
      if (run_len_d == RW'(RUN_LIMIT)) begin
        fault_d = 1'b1;
      end
    end
  end

`ifdef VBB_RNG_VN_DEBIAS_EN
  logic pair_pending_q, pair_pending_d;
  logic pair_first_q, pair_first_d;

  // Von Neumann pairing: 10 yields 1 and 01 yields 0, which is exactly the
  // first bit of an unequal pair. Equal pairs produce nothing.
  always_comb begin
    pair_pending_d = pair_pending_q;
    pair_first_d   = pair_first_q;
    pack_valid     = 1'b0;
    pack_bit       = pair_first_q;
    if (bit_valid) begin
      if (!pair_pending_q) begin
        pair_first_d   = bit_in;
        pair_pending_d = 1'b1;
      end else begin
        pair_pending_d = 1'b0;
        pack_valid     = (bit_in != pair_first_q) && !fault_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_pending_q <= 1'b0;
      pair_first_q   <= 1'b0;
    end else begin
      pair_pending_q <= pair_pending_d;
      pair_first_q   <= pair_first_d;
    end
  end
`else
  assign pack_valid = bit_valid && !fault_q;
  assign pack_bit   = bit_in;
`endif

  // Packer and output register. The output is free when empty or being
  // consumed this edge; a full accumulator drains first, and a bit arriving
  // on that same edge becomes the first bit of the following word.
  always_comb begin
    out_free     = !word_valid_q || word_ready;
    acc_d        = acc_q;
    count_d      = count_q;
    acc_full_d   = acc_full_q;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q;
    overrun_d    = 1'b0;

    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    if (acc_full_q) begin
      if (out_free) begin
        word_out_d   = acc_q;
        word_valid_d = 1'b1;
        acc_full_d   = 1'b0;
        if (pack_valid) begin
          acc_d   = {acc_q[OUT_WIDTH-2:0], pack_bit};
          count_d = CW'(1);
        end
      end else if (pack_valid) begin
        overrun_d = 1'b1;
      end
    end else if (pack_valid) begin
      if (count_q == CW'(OUT_WIDTH - 1)) begin
        count_d = '0;
        if (out_free) begin
          word_out_d   = {acc_q[OUT_WIDTH-2:0], pack_bit};
          word_valid_d = 1'b1;
        end else begin
          acc_d      = {acc_q[OUT_WIDTH-2:0], pack_bit};
          acc_full_d = 1'b1;
        end
      end else begin
        acc_d   = {acc_q[OUT_WIDTH-2:0], pack_bit};
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      count_q      <= '0;
      acc_full_q   <= 1'b0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      overrun_q    <= 1'b0;
      run_len_q    <= '0;
      prev_bit_q   <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      count_q      <= count_d;
      acc_full_q   <= acc_full_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      fault_q      <= fault_d;
      overrun_q    <= overrun_d;
      run_len_q    <= run_len_d;
      prev_bit_q   <= prev_bit_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign fault      = fault_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_rng_word_packer.sv
// tb_rng_word_packer
//   Directed testbench for rng_word_packer with OUT_WIDTH=8, RUN_LIMIT=32.
//   Scenarios follow the build: the default build exercises plain packing,
//   back-pressure, overrun, the health test and mid-word reset; a build with
//   VBB_RNG_VN_DEBIAS_EN defined exercises the debiaser, its restart on
//   reset and the stuck-source behaviour through the debiaser.
module tb_rng_word_packer;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic       fault;
  logic       overrun;

  int test_count;
  int fail_count;

  rng_word_packer #(
    .OUT_WIDTH(8),
    .RUN_LIMIT(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .fault     (fault),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every comparison and reports any mismatch on one line.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge and returns just after
  // the following rising edge, where outputs are sampled.
  task automatic applyStimulus(input logic b, input logic v, input logic r);
    @(negedge clk);
    bit_in     = b;
    bit_valid  = v;
    word_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic feedWord(input logic [7:0] w, input logic r);
    for (int i = 7; i >= 0; i--) applyStimulus(w[i], 1'b1, r);
  endtask

  task automatic doReset();
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

`ifdef VBB_RNG_VN_DEBIAS_EN
  // Raw pairs 10,00,01,10,11,10,01,01,10,01 which debias to 8'hB2.
  logic [19:0] vn_seq;
  logic        valid_seen;
  logic        overrun_seen;

  task automatic feedVnSeq(input logic r);
    for (int i = 19; i >= 0; i--) begin
      applyStimulus(vn_seq[i], 1'b1, r);
      if (i > 0 && word_valid) valid_seen = 1'b1;
      if (overrun) overrun_seen = 1'b1;
    end
  endtask
`endif

  initial begin
    test_count = 0;
    fail_count = 0;
    rst        = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    #12;
    checkOutput("reset word_out", 32'(word_out), 32'h0);
    checkOutput("reset word_valid", 32'(word_valid), 32'h0);
    checkOutput("reset fault", 32'(fault), 32'h0);
    checkOutput("reset overrun", 32'(overrun), 32'h0);
    rst = 1'b0;

`ifndef VBB_RNG_VN_DEBIAS_EN
    // Plain packing with an always-ready consumer.
    doReset();
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(8'hB2 >> i, 1'b1, 1'b1);
      if (i == 1) checkOutput("T1 valid before last bit", 32'(word_valid), 32'h0);
    end
    checkOutput("T1 word_out", 32'(word_out), 32'hB2);
    checkOutput("T1 word_valid", 32'(word_valid), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("T1 valid after handshake", 32'(word_valid), 32'h0);
    checkOutput("T1 word_out kept", 32'(word_out), 32'hB2);

    // Back-pressure: two words fill output and accumulator, a third bit is dropped.
    doReset();
    feedWord(8'hB2, 1'b0);
    checkOutput("T3 first word", 32'(word_out), 32'hB2);
    feedWord(8'h5A, 1'b0);
    checkOutput("T3 held word", 32'(word_out), 32'hB2);
    checkOutput("T3 held valid", 32'(word_valid), 32'h1);
    checkOutput("T3 no overrun yet", 32'(overrun), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("T3 overrun pulse", 32'(overrun), 32'h1);
    checkOutput("T3 word_out during overrun", 32'(word_out), 32'hB2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("T3 overrun cleared", 32'(overrun), 32'h0);
    checkOutput("T3 drained word", 32'(word_out), 32'h5A);
    checkOutput("T3 drained valid", 32'(word_valid), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("T3 valid held without ready", 32'(word_valid), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("T3 valid after last handshake", 32'(word_valid), 32'h0);

    // A bit arriving on the draining edge starts the next word.
    doReset();
    feedWord(8'hB2, 1'b0);
    feedWord(8'h5A, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(8'hC3 >> i, 1'b1, 1'b1);
      if (i == 7) checkOutput("T3b drain word", 32'(word_out), 32'h5A);
    end
    checkOutput("T3b next word", 32'(word_out), 32'hC3);
    checkOutput("T3b next valid", 32'(word_valid), 32'h1);

    // Health test: 31 ones do not trip; a zero run of 32 does.
    doReset();
    for (int i = 0; i < 31; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("T4 31 ones no fault", 32'(fault), 32'h0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("T4 run of 31 no fault", 32'(fault), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("T4 run of 32 fault", 32'(fault), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("T4 fault sticky", 32'(fault), 32'h1);
    checkOutput("T4 no word after fault", 32'(word_valid), 32'h0);
    checkOutput("T4 no overrun after fault", 32'(overrun), 32'h0);

    // Reset mid-word discards partial state and clears outputs at once.
    doReset();
    feedWord(8'hA5, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("T5 word before reset", 32'(word_out), 32'hA5);
    bit_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checkOutput("T5 async word_out", 32'(word_out), 32'h0);
    checkOutput("T5 async word_valid", 32'(word_valid), 32'h0);
    checkOutput("T5 async fault", 32'(fault), 32'h0);
    #1;
    rst = 1'b0;
    feedWord(8'h3C, 1'b1);
    checkOutput("T5 word after reset", 32'(word_out), 32'h3C);
    checkOutput("T5 valid after reset", 32'(word_valid), 32'h1);
`else
    vn_seq = 20'h86E59;

    // Debiased packing of a known pair sequence.
    doReset();
    valid_seen   = 1'b0;
    overrun_seen = 1'b0;
    feedVnSeq(1'b1);
    checkOutput("T2 word_out", 32'(word_out), 32'hB2);
    checkOutput("T2 word_valid", 32'(word_valid), 32'h1);
    checkOutput("T2 no early word", 32'(valid_seen), 32'h0);
    checkOutput("T2 no overrun", 32'(overrun_seen), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("T2 single word", 32'(word_valid), 32'h0);

    // A half pair before reset must not shift the pairing afterwards.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    doReset();
    valid_seen = 1'b0;
    feedVnSeq(1'b1);
    checkOutput("T2b pairing restart", 32'(word_out), 32'hB2);
    checkOutput("T2b valid", 32'(word_valid), 32'h1);

    // Stuck-high source: fault, and no word appears.
    doReset();
    valid_seen   = 1'b0;
    overrun_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      if (word_valid) valid_seen = 1'b1;
      if (overrun) overrun_seen = 1'b1;
    end
    checkOutput("T6 fault", 32'(fault), 32'h1);
    checkOutput("T6 no word", 32'(valid_seen), 32'h0);
    checkOutput("T6 no overrun", 32'(overrun_seen), 32'h0);

    // A word held before the fault is still handed off.
    doReset();
    valid_seen   = 1'b0;
    overrun_seen = 1'b0;
    feedVnSeq(1'b0);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (overrun) overrun_seen = 1'b1;
    end
    checkOutput("T6b fault", 32'(fault), 32'h1);
    checkOutput("T6b held word", 32'(word_out), 32'hB2);
    checkOutput("T6b held valid", 32'(word_valid), 32'h1);
    checkOutput("T6b no overrun", 32'(overrun_seen), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("T6b handed off", 32'(word_valid), 32'h0);
    checkOutput("T6b word kept", 32'(word_out), 32'hB2);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
